// File: rtl/amdc_spi_adc_pkg.sv
// Shared encodings and sizes for the AD4011 responder emulator.
package amdc_spi_adc_pkg;

  localparam int FRAME_BITS = 18;
  localparam int DLY_DEPTH  = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_READY = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

endpackage

// File: rtl/amdc_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with single-cycle rise/fall pulses.
module amdc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/amdc_spi_adc_emulator.sv
// AD4011 responder emulator: shifts two latched words out on sclk falls,
// followed by a programmable per-channel delay line on miso.
module amdc_spi_adc_emulator #(
  parameter int T_CONV_CYCLES = 64,
  parameter int FRAME_BITS    = amdc_spi_adc_pkg::FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  cnv,
  input  logic                  sclk,
  input  logic [FRAME_BITS-1:0] data_x,
  input  logic [FRAME_BITS-1:0] data_y,
  input  logic [7:0]            delay_cnt,
  output logic                  miso_x,
  output logic                  miso_y,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  err_short_cnv,
  output logic                  err_abort
);

  import amdc_spi_adc_pkg::*;

  localparam int CNT_W = $clog2(T_CONV_CYCLES + 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_conv_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shx;
  logic [FRAME_BITS-1:0] r_shy;
  logic                  r_sdo_x;
  logic                  r_sdo_y;
  logic                  r_busy;
  logic                  r_frame_done;
  logic [15:0]           r_frame_cnt;
  logic                  r_err_short;
  logic                  r_err_abort;
  logic [DLY_DEPTH-1:0]  r_dly_x;
  logic [DLY_DEPTH-1:0]  r_dly_y;

  logic                  w_cnv_rise;
  logic                  w_cnv_fall;
  logic                  w_sclk_fall;
  logic                  w_unused_sclk_rise;
  logic [7:0]            w_tap;

  amdc_sync_edge u_sync_cnv (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(cnv),
    .o_rise (w_cnv_rise),
    .o_fall (w_cnv_fall)
  );

  amdc_sync_edge u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(sclk),
    .o_rise (w_unused_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // cnv rise is tested before sclk fall in READY/SHIFT so a restart always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_conv_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shx        <= '0;
      r_shy        <= '0;
      r_sdo_x      <= 1'b0;
      r_sdo_y      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_err_short  <= 1'b0;
      r_err_abort  <= 1'b0;
    end else if (!enable) begin
      r_state      <= ST_IDLE;
      r_conv_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_sdo_x      <= 1'b0;
      r_sdo_y      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_short  <= 1'b0;
      r_err_abort  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cnv_rise) begin
            r_state    <= ST_CONV;
            r_shx      <= data_x;
            r_shy      <= data_y;
            r_conv_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_CONV: begin
          if (w_cnv_fall) begin
            if (r_conv_cnt >= CNT_W'(T_CONV_CYCLES)) begin
              r_state   <= ST_READY;
              r_bit_cnt <= '0;
            end else begin
              r_state     <= ST_IDLE;
              r_err_short <= 1'b1;
              r_busy      <= 1'b0;
            end
          end else if (r_conv_cnt != CNT_W'(T_CONV_CYCLES)) begin
            r_conv_cnt <= r_conv_cnt + 1'b1;
          end
        end
        ST_READY, ST_SHIFT: begin
          if (w_cnv_rise) begin
            r_state     <= ST_CONV;
            r_err_abort <= 1'b1;
            r_shx       <= data_x;
            r_shy       <= data_y;
            r_conv_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_sdo_x     <= 1'b0;
            r_sdo_y     <= 1'b0;
          end else if (w_sclk_fall) begin
            if (r_bit_cnt == BIT_W'(FRAME_BITS)) begin
              r_state      <= ST_IDLE;
              r_sdo_x      <= 1'b0;
              r_sdo_y      <= 1'b0;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
              r_frame_cnt  <= r_frame_cnt + 16'd1;
            end else begin
              r_state   <= ST_SHIFT;
              r_sdo_x   <= r_shx[FRAME_BITS-1];
              r_sdo_y   <= r_shy[FRAME_BITS-1];
              r_shx     <= {r_shx[FRAME_BITS-2:0], 1'b0};
              r_shy     <= {r_shy[FRAME_BITS-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Free-running line; it flushes itself because sdo is held at 0 outside SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly_x <= '0;
      r_dly_y <= '0;
    end else begin
      r_dly_x <= {r_dly_x[DLY_DEPTH-2:0], r_sdo_x};
      r_dly_y <= {r_dly_y[DLY_DEPTH-2:0], r_sdo_y};
    end
  end

  always_comb begin
    w_tap = delay_cnt - 8'd1;
    if (delay_cnt == '0) begin
      miso_x = r_sdo_x;
      miso_y = r_sdo_y;
    end else begin
      miso_x = r_dly_x[w_tap];
      miso_y = r_dly_y[w_tap];
    end
  end

  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign frame_cnt     = r_frame_cnt;
  assign err_short_cnv = r_err_short;
  assign err_abort     = r_err_abort;

endmodule

// File: tb/tb_amdc_spi_adc_emulator.sv
// Bench for amdc_spi_adc_emulator: table of frames plus abort, reset and wrap sequences.
module tb_amdc_spi_adc_emulator;

  localparam int T_CONV = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        cnv;
  logic        sclk;
  logic [17:0] data_x;
  logic [17:0] data_y;
  logic [7:0]  delay_cnt;
  logic        miso_x;
  logic        miso_y;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        err_short_cnv;
  logic        err_abort;

  always #5 clk = ~clk;

  amdc_spi_adc_emulator #(
    .T_CONV_CYCLES(T_CONV),
    .FRAME_BITS   (18)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cnv          (cnv),
    .sclk         (sclk),
    .data_x       (data_x),
    .data_y       (data_y),
    .delay_cnt    (delay_cnt),
    .miso_x       (miso_x),
    .miso_y       (miso_y),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .err_short_cnv(err_short_cnv),
    .err_abort    (err_abort)
  );

  typedef struct {
    int         cyc;
    logic [1:0] bits;
  } sb_t;

  typedef struct {
    logic [17:0] dx;
    logic [17:0] dy;
    logic [7:0]  dly;
    int          len;
    int          nfalls;
    int          half;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[6];
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   fd_seen = 0;
  int   exp_fc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  sb_t e;
  always @(negedge clk) begin
    if (frame_done) fd_seen++;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      chk("miso_xy", {30'd0, miso_x, miso_y}, {30'd0, e.bits});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [1:0] exp_bits(input logic [17:0] dx, input logic [17:0] dy,
                                          input bit valid, input int k);
    if (!valid || k < 1 || k > 18) return 2'b00;
    return {dx[18-k], dy[18-k]};
  endfunction

  // Each fall is checked one cycle before and exactly at the expected miso change.
  task automatic run_falls(input int n, input int half, input logic [17:0] dx,
                           input logic [17:0] dy, input int dly, input bit valid);
    sb_t s;
    for (int k = 1; k <= n; k++) begin
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
      s.cyc = cyc + 2 + dly; s.bits = exp_bits(dx, dy, valid, k - 1); sbq.push_back(s);
      s.cyc = cyc + 3 + dly; s.bits = exp_bits(dx, dy, valid, k);     sbq.push_back(s);
      tick(half);
    end
  endtask

  task automatic do_frame(input vec_t v, input bit chk_busy);
    bit valid;
    valid     = (v.len - 1 >= T_CONV);
    data_x    = v.dx;
    data_y    = v.dy;
    delay_cnt = v.dly;
    cnv       = 1'b1;
    if (chk_busy) begin
      tick(2);
      chk("busy_before_sync", busy, 0);
      tick(1);
      chk("busy_3clk", busy, 1);
      tick(v.len - 3);
    end else begin
      tick(v.len);
    end
    cnv = 1'b0;
    tick(10);
    run_falls(v.nfalls, v.half, v.dx, v.dy, int'(v.dly), valid);
    tick(int'(v.dly) + 12);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   fd0;
    bit   valid;
    vec_t v;

    vecs[0] = '{18'h2AAAA, 18'h15555, 8'd0,   70, 19, 10};
    vecs[1] = '{18'h2AAAA, 18'h15555, 8'd108, 70, 19, 10};
    vecs[2] = '{18'h3FFFF, 18'h3FFFF, 8'd0,   30, 19, 10};
    vecs[3] = '{18'h3C5A1, 18'h0F0F0, 8'd0,   70, 20, 10};
    vecs[4] = '{18'h12345, 18'h3FFFF, 8'd1,   66, 19, 4};
    vecs[5] = '{18'h00001, 18'h20000, 8'd255, 70, 19, 6};

    rst_n = 1'b0; enable = 1'b0; cnv = 1'b0; sclk = 1'b0;
    data_x = '0; data_y = '0; delay_cnt = '0;
    tick(3);
    chk("rst_miso", {miso_x, miso_y}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_short", err_short_cnv, 0);
    chk("rst_err_abort", err_abort, 0);
    rst_n = 1'b1;
    tick(2);

    foreach (vecs[i]) begin
      enable = 1'b0;
      tick(2);
      chk("en_clr_short", err_short_cnv, 0);
      chk("en_clr_abort", err_abort, 0);
      chk("en_hold_fc", frame_cnt, exp_fc);
      enable = 1'b1;
      tick(1);
      fd0   = fd_seen;
      valid = (vecs[i].len - 1 >= T_CONV);
      do_frame(vecs[i], 1'b1);
      if (valid && vecs[i].nfalls >= 19) exp_fc++;
      chk("frame_cnt", frame_cnt, exp_fc);
      chk("frame_done_pulses", fd_seen - fd0, (valid && vecs[i].nfalls >= 19) ? 1 : 0);
      chk("err_short", err_short_cnv, valid ? 0 : 1);
      chk("err_abort_none", err_abort, 0);
      chk("busy_end", busy, 0);
    end

    // Abort: cnv re-rises after 9 falls, the relatched frame then runs to completion.
    enable = 1'b0; tick(2); enable = 1'b1; tick(1);
    fd0 = fd_seen;
    data_x = 18'h2AAAA; data_y = 18'h15555; delay_cnt = 8'd0;
    cnv = 1'b1; tick(70); cnv = 1'b0; tick(10);
    run_falls(9, 10, 18'h2AAAA, 18'h15555, 0, 1'b1);
    tick(10);
    data_x = 18'h3FFFF; data_y = 18'h3FFFF;
    cnv = 1'b1; tick(6);
    chk("abort_flag", err_abort, 1);
    chk("abort_miso_zero", {miso_x, miso_y}, 0);
    tick(64); cnv = 1'b0; tick(10);
    run_falls(19, 10, 18'h3FFFF, 18'h3FFFF, 0, 1'b1);
    tick(12);
    exp_fc++;
    chk("abort_frame_cnt", frame_cnt, exp_fc);
    chk("abort_frame_done", fd_seen - fd0, 1);
    chk("abort_flag_sticky", err_abort, 1);

    // Asynchronous reset in the middle of SHIFT.
    enable = 1'b0; tick(2); enable = 1'b1; tick(1);
    data_x = 18'h3FFFF; data_y = 18'h3FFFF; delay_cnt = 8'd0;
    cnv = 1'b1; tick(70); cnv = 1'b0; tick(10);
    run_falls(5, 10, 18'h3FFFF, 18'h3FFFF, 0, 1'b1);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_miso", {miso_x, miso_y}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_frame_cnt", frame_cnt, 0);
    chk("arst_err_abort", err_abort, 0);
    tick(3);
    rst_n = 1'b1;
    exp_fc = 0;
    tick(3);
    fd0 = fd_seen;
    v = '{18'h0BEEF, 18'h2D2D2, 8'd3, 70, 19, 8};
    do_frame(v, 1'b1);
    exp_fc++;
    chk("post_rst_frame_cnt", frame_cnt, exp_fc);
    chk("post_rst_frame_done", fd_seen - fd0, 1);

    // Wrap: preload the counter to its maximum and complete one frame.
    force dut.r_frame_cnt = 16'hFFFF;
    tick(1);
    release dut.r_frame_cnt;
    tick(1);
    v = '{18'h1C3E7, 18'h00FF0, 8'd0, 70, 19, 10};
    do_frame(v, 1'b0);
    chk("wrap_frame_cnt", frame_cnt, 0);

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
